audio_frame_scheduler: RTL

Sequences sample delivery into the I2S audio I/O block. Software (via AXI glue) pushes stereo frames for both output channels (Line Out, Phones Out) into an internal FIFO. On every frame-start `LOAD` strobe from the audio clock generator, the block pops one frame and presents it on the four 24-bit output-channel buses. It also handles underrun, raises a low-watermark refill IRQ, and reports FIFO level.

---
 rtl/theremin_audio_pkg.sv | 18 +
 rtl/audio_frame_fifo.sv | 54 +++++
 rtl/audio_frame_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/theremin_audio_pkg.sv
// Shared audio types for the theremin audio path: 24-bit samples and the
// four-sample stereo frame {l0, r0, l1, r1} with l0 in the top bits.
package theremin_audio_pkg;
  localparam int AUDIO_SAMPLE_BITS = 24;

  typedef logic [AUDIO_SAMPLE_BITS-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t l0;
    audio_sample_t r0;
    audio_sample_t l1;
    audio_sample_t r1;
  } audio_frame_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with flush. Pointers carry an extra wrap bit so
// full and empty are distinguishable; storage has no reset (distributed RAM).
module audio_frame_fifo
  import theremin_audio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  audio_frame_t          din,
  output audio_frame_t          head,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   level_nxt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  audio_frame_t            mem [DEPTH];
  logic [DEPTH_LOG2:0]     wptr, rptr;
  logic                    full, do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_comb begin
    level_nxt = level;
    if (flush)                 level_nxt = '0;
    else if (do_push & ~do_pop) level_nxt = level + 1'b1;
    else if (do_pop & ~do_push) level_nxt = level - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
    end
  end
endmodule

// File: rtl/audio_frame_scheduler.sv
// Pops one frame per LOAD strobe onto the I2S channel buses; tracks underrun
// and watermark IRQ. Define AUDIO_UNDERRUN_COUNT_EN to build the underrun counter.
module audio_frame_scheduler
  import theremin_audio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WATERMARK  = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LOAD,
  input  logic                    ENABLE,
  input  logic                    WR_VALID,
  output logic                    WR_READY,
  input  logic [95:0]             WR_FRAME,
  output logic [23:0]             OUT_LEFT_CHANNEL0,
  output logic [23:0]             OUT_RIGHT_CHANNEL0,
  output logic [23:0]             OUT_LEFT_CHANNEL1,
  output logic [23:0]             OUT_RIGHT_CHANNEL1,
  output logic [DEPTH_LOG2:0]     LEVEL,
  input  logic                    IRQ_EN,
  output logic                    IRQ,
  input  logic                    ACK,
  output logic                    UNDERRUN,
  input  logic                    UNDERRUN_CLR,
  output logic [15:0]             UNDERRUN_COUNT
);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] WM_LVL   = (DEPTH_LOG2+1)'(WATERMARK);

  audio_frame_t            wr_frame, head, out_q;
  logic                    empty, push, pop, und_ev, irq_set;
  logic [DEPTH_LOG2:0]     level_nxt, post_pop;

  assign wr_frame = WR_FRAME;
  assign push     = WR_VALID & WR_READY & ENABLE;
  assign pop      = LOAD & ENABLE & ~empty;
  assign und_ev   = LOAD & ENABLE & empty;
  assign post_pop = LEVEL - {{DEPTH_LOG2{1'b0}}, pop};
  assign irq_set  = LOAD & ENABLE & IRQ_EN & (post_pop <= WM_LVL);

  audio_frame_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (~ENABLE),
    .push      (push),
    .pop       (pop),
    .din       (wr_frame),
    .head      (head),
    .empty     (empty),
    .level     (LEVEL),
    .level_nxt (level_nxt)
  );

  // Outputs hold the last frame across underruns; disable mutes them.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) out_q <= '0;
    else if (pop)         out_q <= head;
  end

  assign OUT_LEFT_CHANNEL0  = out_q.l0;
  assign OUT_RIGHT_CHANNEL0 = out_q.r0;
  assign OUT_LEFT_CHANNEL1  = out_q.l1;
  assign OUT_RIGHT_CHANNEL1 = out_q.r1;

  always_ff @(posedge CLK) begin
    if (RESET) WR_READY <= 1'b0;
    else       WR_READY <= ENABLE & (level_nxt != FULL_LVL);
  end

  // A new qualifying LOAD overrides a simultaneous acknowledge.
  always_ff @(posedge CLK) begin
    if (RESET)          IRQ <= 1'b0;
    else if (irq_set)   IRQ <= 1'b1;
    else if (IRQ & ACK) IRQ <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET)             UNDERRUN <= 1'b0;
    else if (und_ev)       UNDERRUN <= 1'b1;
    else if (UNDERRUN_CLR) UNDERRUN <= 1'b0;
  end

`ifdef AUDIO_UNDERRUN_COUNT_EN
  logic [15:0] und_cnt;

  always_ff @(posedge CLK) begin
    if (RESET)             und_cnt <= '0;
    else if (und_ev)       und_cnt <= UNDERRUN_CLR ? 16'd1 : sat_inc16(und_cnt);
    else if (UNDERRUN_CLR) und_cnt <= '0;
  end

  assign UNDERRUN_COUNT = und_cnt;
`else
  assign UNDERRUN_COUNT = 16'h0000;
`endif
endmodule
